// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_arb_pkg: state encodings, owner tags and default widths for the data-memory arbiter
package dmem_arb_pkg;
   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 32;
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_CPU      = 2'd1;
   localparam logic [1:0] S_IO       = 2'd2;
   localparam logic [1:0] S_IO_BURST = 2'd3;
   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_IO  = 1'b1;
   typedef struct packed {
      logic valid;
      logic owner;
   } rd_tag_t;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: CPU and IO request ports plus the shared synchronous data-memory port
interface dmem_port_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              cpu_req, cpu_we, cpu_stall, cpu_rvalid;
   logic [31:0]       cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              io_req, io_we, io_lock, io_gnt, io_rvalid;
   logic [ADDR_W-1:0] io_addr;
   logic [DATA_W-1:0] io_wdata, io_rdata;
   logic [ADDR_W-1:0] address_dmem;
   logic [DATA_W-1:0] d_dmem, q_dmem;
   logic              wren;
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, io_req, io_we, io_lock, io_addr, io_wdata, q_dmem,
      output cpu_stall, cpu_rdata, cpu_rvalid, io_gnt, io_rdata, io_rvalid, address_dmem, d_dmem, wren
   );
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, io_req, io_we, io_lock, io_addr, io_wdata, q_dmem,
      input  cpu_stall, cpu_rdata, cpu_rvalid, io_gnt, io_rdata, io_rvalid, address_dmem, d_dmem, wren
   );
endinterface

// File: rtl/dmem_port_arbiter_sat_counter.sv
// arb_sat_counter: up-counter that saturates at LIMIT, with synchronous clear
module arb_sat_counter #(
   parameter int W     = 4,
   parameter int LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         at_limit
);
   assign at_limit = count == W'(LIMIT);
   always_ff @(posedge clk)
      if (rst || clr) count <= '0;
      else if (inc && !at_limit) count <= count + W'(1);
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one synchronous data-memory port between the CPU and the IO engine,
// with CPU-first priority, IO starvation relief, bounded IO bursts and read-data return routing.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_BURST    = 8
) (
   input logic clk,
   input logic rst,
   dmem_port_arbiter_if.slave bus
);
   logic [1:0]        state;
   logic [3:0]        starve_cnt, burst_cnt;
   logic              starve_max, burst_max, burst_live, burst_over, io_first;
   logic              cpu_gnt, io_gnt, io_burst;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, cpu_rdata_q, io_rdata_q;
   rd_tag_t           tag;
   logic              unused_bits;

   assign unused_bits = ^{bus.cpu_addr[31:ADDR_W], starve_cnt, burst_cnt};

   // An expired burst must hand at least one cycle to a waiting CPU.
   always_comb begin
      burst_live = state == S_IO_BURST && bus.io_lock && !burst_max;
      burst_over = state == S_IO_BURST && burst_max && bus.cpu_req;
      io_first   = bus.io_req && (starve_max || burst_live) && !burst_over;
      cpu_gnt    = !rst && bus.cpu_req && !io_first;
      io_gnt     = !rst && bus.io_req && !cpu_gnt;
      io_burst   = io_gnt && bus.io_lock;
   end

   arb_sat_counter #(.W(4), .LIMIT(STARVE_LIMIT)) u_starve (
      .clk(clk), .rst(rst), .inc(bus.io_req && !io_gnt), .clr(!bus.io_req || io_gnt),
      .count(starve_cnt), .at_limit(starve_max)
   );

   arb_sat_counter #(.W(4), .LIMIT(MAX_BURST)) u_burst (
      .clk(clk), .rst(rst), .inc(io_burst), .clr(!io_burst),
      .count(burst_cnt), .at_limit(burst_max)
   );

   // Idle cycles replay the last address/data so the memory pins never glitch.
   assign bus.cpu_stall    = !rst && bus.cpu_req && !cpu_gnt;
   assign bus.io_gnt       = io_gnt;
   assign bus.address_dmem = rst ? '0 : cpu_gnt ? bus.cpu_addr[ADDR_W-1:0] : io_gnt ? bus.io_addr : addr_q;
   assign bus.d_dmem       = rst ? '0 : cpu_gnt ? bus.cpu_wdata : io_gnt ? bus.io_wdata : wdata_q;
   assign bus.wren         = cpu_gnt ? bus.cpu_we : io_gnt && bus.io_we;
   assign bus.cpu_rvalid   = !rst && tag.valid && tag.owner == OWNER_CPU;
   assign bus.io_rvalid    = !rst && tag.valid && tag.owner == OWNER_IO;
   assign bus.cpu_rdata    = rst ? '0 : bus.cpu_rvalid ? bus.q_dmem : cpu_rdata_q;
   assign bus.io_rdata     = rst ? '0 : bus.io_rvalid ? bus.q_dmem : io_rdata_q;

   always_ff @(posedge clk)
      if (rst) begin
         state       <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         io_rdata_q  <= '0;
         tag         <= '0;
      end else begin
         state       <= cpu_gnt ? S_CPU : io_gnt ? (bus.io_lock ? S_IO_BURST : S_IO) : S_IDLE;
         addr_q      <= bus.address_dmem;
         wdata_q     <= bus.d_dmem;
         cpu_rdata_q <= bus.cpu_rdata;
         io_rdata_q  <= bus.io_rdata;
         tag         <= '{valid: (cpu_gnt && !bus.cpu_we) || (io_gnt && !bus.io_we),
                          owner: io_gnt ? OWNER_IO : OWNER_CPU};
      end
endmodule
